pc_stack_unit: RTL



---
 rtl/pc_stack_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// Program-counter unit: increment, absolute load, PC-relative branch and
// CALL/RET through an internal return-address stack with sticky error flags.
module pc_stack_unit #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned OFFSET_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  localparam int unsigned DEPTH_WIDTH = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pc_en,
  input  logic [2:0]              op,
  input  logic [ADDR_WIDTH-1:0]   pc_in,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic                    err_clr,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic [ADDR_WIDTH-1:0]   ret_top,
  output logic [DEPTH_WIDTH-1:0]  depth,
  output logic                    stack_full,
  output logic                    stack_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned IDX_WIDTH = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    OpInc    = 3'b000,
    OpLoad   = 3'b001,
    OpBranch = 3'b010,
    OpCall   = 3'b011,
    OpRet    = 3'b100,
    OpHold   = 3'b101
  } op_e;

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic [ADDR_WIDTH-1:0]  stack_q [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0]  pc_inc, off_ext, top_entry;
  logic [IDX_WIDTH-1:0]   push_idx, top_idx;
  logic                   full, empty, push, ovf_evt, unf_evt;

  // Decode stack status and arithmetic helpers from registered state.
  always_comb begin
    full      = (depth_q == DEPTH_WIDTH'(STACK_DEPTH));
    empty     = (depth_q == '0);
    // Indices only used when the stack is not full / not empty respectively.
    push_idx  = IDX_WIDTH'(depth_q);
    top_idx   = IDX_WIDTH'(depth_q - DEPTH_WIDTH'(1));
    top_entry = stack_q[top_idx];
    pc_inc    = pc_q + ADDR_WIDTH'(1);
    off_ext   = ADDR_WIDTH'($signed(offset));
  end

  // Next-state logic for PC, stack depth and sticky error flags.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push    = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (pc_en) begin
      case (op_e'(op))
        OpInc:    pc_d = pc_inc;
        OpLoad:   pc_d = pc_in;
        OpBranch: pc_d = pc_q + off_ext;
        OpCall: begin
          if (!full) begin
            push    = 1'b1;
            depth_d = depth_q + DEPTH_WIDTH'(1);
            pc_d    = pc_in;
          end else begin
            pc_d    = pc_inc;
            ovf_evt = 1'b1;
          end
        end
        OpRet: begin
          if (!empty) begin
            depth_d = depth_q - DEPTH_WIDTH'(1);
            pc_d    = top_entry;
          end else begin
            pc_d    = pc_inc;
            unf_evt = 1'b1;
          end
        end
        default: ; // HOLD and reserved encodings leave state unchanged
      endcase
    end
    // A new error event wins over a same-cycle clear.
    overflow_d  = ovf_evt | (overflow_q & ~err_clr);
    underflow_d = unf_evt | (underflow_q & ~err_clr);
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Return-address storage; contents are irrelevant while depth is zero.
  always_ff @(posedge clk) begin
    if (push) stack_q[push_idx] <= pc_inc;
  end

  // Outputs come straight from registered state.
  always_comb begin
    pc_out      = pc_q;
    depth       = depth_q;
    ret_top     = empty ? '0 : top_entry;
    stack_full  = full;
    stack_empty = empty;
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

endmodule
